// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the control decoder.
// Holds the datapath width, the default reset PC, and the bit positions
// of the opcode/funct3 fields so that every consumer slices identically.
package fetch_unit_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam int unsigned OPC_LSB = 0;
   localparam int unsigned OPC_MSB = 6;
   localparam int unsigned F3_LSB  = 12;
   localparam int unsigned F3_MSB  = 14;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and memory (slave).
//   imem_req_valid/ready/addr : word fetch request channel
//   imem_rsp_valid/data       : in-order response channel, no backpressure
interface fetch_unit_if #(
   parameter int unsigned XLEN = fetch_unit_pkg::XLEN
);
   import fetch_unit_pkg::*;

   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two).
//   clk, rst : clock, synchronous active-high reset
//   flush    : empties the FIFO; a push in the same cycle is discarded
//   push/pop : write wdata / advance head; pop on empty is ignored
//   rdata    : head entry
//   count    : number of valid entries
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   import fetch_unit_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop, full;

   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && (!full || do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   PC_Src          : redirect from control (branch taken / jump)
//   pc_target       : redirect address (low two bits ignored)
//   stall           : downstream not accepting this cycle
//   instr_valid     : head instruction valid
//   instr, instr_pc : head instruction word and its address
//   opcode, funct3  : fields sliced from the head instruction
module fetch_unit #(
   parameter int unsigned     XLEN     = fetch_unit_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(fetch_unit_pkg::RESET_PC_DEFAULT),
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   fetch_unit_if.master    imem,
   input  logic            PC_Src,
   input  logic [XLEN-1:0] pc_target,
   input  logic            stall,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3
);
   import fetch_unit_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]     ib_count, aq_count;
   logic [2*XLEN-1:0] ib_head;
   logic [XLEN-1:0]   aq_head;

   logic req_valid, req_fire, rsp, rsp_live, ib_push, ib_pop;

   // Credit covers both in-flight requests (including ones marked for drop)
   // and buffered instructions, so the buffer can never overflow.
   assign req_valid = !rst && !PC_Src &&
                      (({1'b0, outstanding_q} + {1'b0, ib_count}) < (CW+1)'(DEPTH));
   assign req_fire  = req_valid && imem.imem_req_ready;
   assign rsp       = imem.imem_rsp_valid;
   assign rsp_live  = rsp && (drop_cnt_q == '0);
   assign ib_push   = rsp_live && !PC_Src;
   assign ib_pop    = instr_valid && !stall && !PC_Src;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_q;

   always_comb begin
      pc_d          = pc_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp);
      drop_cnt_d    = drop_cnt_q;
      if (PC_Src) begin
         pc_d       = pc_target & ~XLEN'(3);
         // Everything still in flight after this edge must be discarded;
         // a response landing this cycle is already gone.
         drop_cnt_d = outstanding_q - CW'(rsp);
      end else begin
         if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (rsp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   // Address of every live request, popped as its response returns.
   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addrq (
      .clk   (clk),
      .rst   (rst),
      .flush (PC_Src),
      .push  (req_fire),
      .pop   (rsp_live),
      .wdata (pc_q),
      .rdata (aq_head),
      .count (aq_count)
   );

   fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ibuf (
      .clk   (clk),
      .rst   (rst),
      .flush (PC_Src),
      .push  (ib_push),
      .pop   (ib_pop),
      .wdata ({imem.imem_rsp_data, aq_head}),
      .rdata (ib_head),
      .count (ib_count)
   );

   assign instr_valid = !rst && (ib_count != '0);
   assign instr       = ib_head[2*XLEN-1:XLEN];
   assign instr_pc    = ib_head[XLEN-1:0];
   assign opcode      = instr[OPC_MSB:OPC_LSB];
   assign funct3      = instr[F3_MSB:F3_LSB];

   a_addrq_tracks: assert property (@(posedge clk) disable iff (rst)
      aq_count == outstanding_q - drop_cnt_q);

endmodule
